uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 25_000_000: input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200: serial bit rate in bits/s.
REQ-003 Parameter CLKS_PER_BIT, default (CLK_HZ + BAUD/2) / BAUD: clocks per serial bit; 217 at the defaults.
REQ-004 Port clk_25mhz, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port data_i, input, 8: byte to send; sampled only on accept.
REQ-007 Port valid_i, input, 1: data_i holds a byte to send.
REQ-008 Port ready_o, output, 1: block can accept a byte this cycle.
REQ-009 Port tx_o, output, 1: serial line; idles high.
REQ-010 Port busy_o, output, 1: a frame is in progress.

Function
REQ-011 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, one stop bit (1). No parity.
REQ-012 Each bit SHALL be held on tx_o for exactly CLKS_PER_BIT cycles, so one frame lasts 10*CLKS_PER_BIT cycles.
REQ-013 A byte is accepted in cycle t when valid_i=1 and ready_o=1. data_i SHALL be latched into the shift register in cycle t.
REQ-014 On accept at cycle t, the start bit SHALL appear on tx_o from cycle t+1.
REQ-015 ready_o SHALL be 1 only in IDLE.
REQ-016 busy_o SHALL equal NOT ready_o.
REQ-017 valid_i and data_i SHALL be ignored while ready_o=0. Changing data_i mid-frame SHALL NOT alter the frame.
REQ-018 The state machine SHALL have states IDLE, START, DATA, STOP.
REQ-019 Transitions: IDLE->START on accept; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after the 8th bit's CLKS_PER_BIT cycles; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-020 The baud counter SHALL reload on every bit boundary and on accept, so bit timing never drifts.
REQ-021 The data bit index SHALL be 3 bits wide and wrap 7->0 on the DATA->STOP transition.
REQ-022 Back-to-back: with valid_i held high, the next accept SHALL occur in the first IDLE cycle after STOP. tx_o SHALL be high for exactly CLKS_PER_BIT+1 cycles between the last data bit and the next start bit.
REQ-023 An elaboration check SHALL fail if CLKS_PER_BIT < 2.

Reset
REQ-024 While rst_n=0 at a rising edge, the next-cycle values SHALL be: state IDLE, tx_o=1, ready_o=1, busy_o=0, baud counter 0, bit index 0.
REQ-025 Reset mid-frame SHALL abandon the frame. tx_o SHALL be 1 from the cycle after the reset edge, with no partial stop bit. The byte SHALL NOT be resent.
REQ-026 An accept SHALL NOT occur in a cycle where rst_n=0.

Structure
REQ-027 Package uart_pkg SHALL hold:
- the state enum tx_state_t {IDLE, START, DATA, STOP};
- a function computing CLKS_PER_BIT from CLK_HZ and BAUD.
REQ-028 Baud timing SHALL be one sub-module, baud_tick, parameterised by CLKS_PER_BIT:
- inputs clk_25mhz, rst_n, restart;
- output tick, one cycle wide every CLKS_PER_BIT cycles after restart.
REQ-029 The shift register, bit index and FSM SHALL live in uart_tx. Target size is 120-400 RTL lines total.

Verification (CLK_HZ=1000, BAUD=100, so CLKS_PER_BIT=10)
REQ-030 Single byte: accept 0xA5 at cycle t -> tx_o is:
- 0 for cycles t+1..t+10;
- then bits 1,0,1,0,0,1,0,1, each for 10 cycles;
- then 1 for 10 cycles.
ready_o returns to 1 at cycle t+101.
REQ-031 Back-to-back: valid_i held with 0x00 then 0xFF -> second start bit begins 11 cycles after the first frame's last data bit ends. Both frames decode correctly in the bench monitor.
REQ-032 Ignore while busy: pulse valid_i with 0x3C at cycle t+40 of a 0x55 frame -> no accept occurs, the 0x55 frame is unchanged, and 0x3C is never transmitted.
REQ-033 Reset mid-frame: rst_n=0 for 1 cycle at t+55 of a frame -> from t+56, tx_o=1 and ready_o=1. A new byte 0x81 then transmits correctly.
REQ-034 Data change: data_i toggles every cycle after accepting 0x0F -> the transmitted frame is exactly 0x0F.
REQ-035 Idle: valid_i=0 for 500 cycles after reset -> tx_o=1, ready_o=1 and busy_o=0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Rounded-to-nearest clocks per serial bit.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: pulses tick for one cycle every CLKS_PER_BIT cycles after restart.
module baud_tick #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk_25mhz,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Reload on restart and on every tick so bit boundaries never drift.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input.
// Handshake: a byte is accepted in any cycle where valid_i && ready_o (and rst_n is high);
// ready_o is high only in IDLE, so valid_i/data_i are ignored for the whole frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 25_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       accept;
  logic       tick;

  assign ready_o = (state_q == IDLE);
  assign busy_o  = ~ready_o;
  assign accept  = valid_i && ready_o && rst_n;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk_25mhz(clk_25mhz),
    .rst_n    (rst_n),
    .restart  (accept),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_o      = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = data_i;
          bit_idx_d = 3'd0;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        tx_o = shift_q[0];
        if (tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          // Index wraps 7->0 on the last data bit, which is also the exit to STOP.
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at CLK_HZ=1000, BAUD=100 (10 clocks per bit).
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk_25mhz;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       tx_o;
  logic       busy_o;

  int vectors = 0;
  int miscompares = 0;

  uart_tx #(
    .CLK_HZ(1000),
    .BAUD  (100)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .rst_n    (rst_n),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .tx_o     (tx_o),
    .busy_o   (busy_o)
  );

  // Clock / reset block
  initial clk_25mhz = 1'b0;
  always #5 clk_25mhz = ~clk_25mhz;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk_25mhz);
  endtask

  // Waits (bounded) for ready, presents a byte for one cycle; returns at cycle t+1.
  task automatic start_frame(input logic [7:0] d);
    int n = 0;
    while (!ready_o && n < 300) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL start_frame_timeout: ready_o=%0b after %0d cycles, required 1", ready_o, n);
    end
    data_i  = d;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  // Samples 10 bit periods starting at the current cycle (t+1); returns at t+101.
  // mode 1: pulse valid_i with 0x3C at t+40. mode 2: toggle data_i every cycle.
  task automatic capture_frame(input int mode, output logic [9:0] bits, output int unstable);
    int off;
    unstable = 0;
    bits = '0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < CPB; k++) begin
        off = 1 + b * CPB + k;
        if (k == 0) bits[b] = tx_o;
        else if (tx_o !== bits[b]) unstable++;
        if (mode == 1 && off == 40) begin
          data_i  = 8'h3C;
          valid_i = 1'b1;
        end
        if (mode == 1 && off == 41) valid_i = 1'b0;
        if (mode == 2) data_i = ~data_i;
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0",
                 tx_o, ready_o, busy_o);
      end
    end
    rst_n   = 1'b1;
    valid_i = 1'b0;
    step();
    vectors++;
    if (tx_o !== 1'b1 || ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_accept: tx=%b ready=%b, required tx=1 ready=1", tx_o, ready_o);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_500: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_single();
    logic [9:0] bits;
    int unstable;
    start_frame(8'hA5);
    vectors++;
    if (ready_o !== 1'b0 || busy_o !== 1'b1 || tx_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_t1: tx=%b ready=%b busy=%b, required tx=0 ready=0 busy=1",
               tx_o, ready_o, busy_o);
    end
    capture_frame(0, bits, unstable);
    vectors++;
    if (bits !== 10'h34A) begin
      miscompares++;
      $display("FAIL single_frame: got %h, required 34a", bits);
    end
    vectors++;
    if (unstable != 0) begin
      miscompares++;
      $display("FAIL single_timing: %0d unstable samples, required 0", unstable);
    end
    vectors++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ready_t101: ready=%b busy=%b, required 1/0", ready_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits;
    int unstable;
    data_i  = 8'h00;
    valid_i = 1'b1;
    step();
    data_i = 8'hFF;
    capture_frame(0, bits, unstable);
    vectors++;
    if (bits !== 10'h200 || unstable != 0) begin
      miscompares++;
      $display("FAIL b2b_frame0: got %h unstable=%0d, required 200 unstable=0", bits, unstable);
    end
    // Cycle t+101: the single idle gap cycle where the second byte is accepted.
    vectors++;
    if (tx_o !== 1'b1 || ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gap: tx=%b ready=%b, required 1/1", tx_o, ready_o);
    end
    step();
    valid_i = 1'b0;
    vectors++;
    if (tx_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_start_at_gap11: tx=%b, required 0", tx_o);
    end
    capture_frame(0, bits, unstable);
    vectors++;
    if (bits !== 10'h3FE || unstable != 0) begin
      miscompares++;
      $display("FAIL b2b_frame1: got %h unstable=%0d, required 3fe unstable=0", bits, unstable);
    end
  endtask

  task automatic test_ignore_busy();
    logic [9:0] bits;
    int unstable;
    int bad = 0;
    start_frame(8'h55);
    capture_frame(1, bits, unstable);
    vectors++;
    if (bits !== 10'h2AA || unstable != 0) begin
      miscompares++;
      $display("FAIL ignore_busy_frame: got %h unstable=%0d, required 2aa unstable=0", bits, unstable);
    end
    for (int i = 0; i < 150; i++) begin
      if (tx_o !== 1'b1 || ready_o !== 1'b1) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL ignore_busy_no_3c: %0d non-idle cycles, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    int unstable;
    int bad = 0;
    start_frame(8'hA5);
    for (int i = 0; i < 54; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if (tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_t56: tx=%b ready=%b busy=%b, required 1/1/0", tx_o, ready_o, busy_o);
    end
    for (int i = 0; i < 120; i++) begin
      if (tx_o !== 1'b1 || ready_o !== 1'b1) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_resend: %0d non-idle cycles, required 0", bad);
    end
    start_frame(8'h81);
    capture_frame(0, bits, unstable);
    vectors++;
    if (bits !== 10'h302 || unstable != 0) begin
      miscompares++;
      $display("FAIL reset_mid_0x81: got %h unstable=%0d, required 302 unstable=0", bits, unstable);
    end
  endtask

  task automatic test_data_change();
    logic [9:0] bits;
    int unstable;
    start_frame(8'h0F);
    capture_frame(2, bits, unstable);
    vectors++;
    if (bits !== 10'h21E || unstable != 0) begin
      miscompares++;
      $display("FAIL data_change_frame: got %h unstable=%0d, required 21e unstable=0", bits, unstable);
    end
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL data_change_ready: ready=%b, required 1", ready_o);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
    step();
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    step();
    test_ignore_busy();
    test_reset_mid_frame();
    test_data_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
